// File: rtl/reg_file_ne.sv
// reg_file_ne: multi-ported register file with byte-enable writes.
// One write port and two combinational read ports. All state changes on the
// falling edge of clk. Reset is synchronous and active-high.
// Optional hardwired-zero register 0 (ZERO_REG) and optional forwarding of a
// pending write to the read ports (BYPASS).
//
// Write port handshake: there is no valid/ready pair. A write is a single-cycle
// request. When we=1 it is consumed on the next falling edge, unless reset=1 on
// that same edge, in which case it is discarded. The write port is always ready.
module reg_file_ne #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/8-1:0]       wbe,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  output logic [WIDTH-1:0]         rdata2
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_stored;   // current contents of the write target
  logic [WIDTH-1:0] w_merged;   // value the write target will take on the edge
  logic             w_wr_zero;  // write aimed at the hardwired zero register
  logic             w_wr_en;    // write actually lands on the next edge
  logic             w_fwd1;     // read port 1 sees the pending write
  logic             w_fwd2;     // read port 2 sees the pending write
  logic             w_rd1_zero; // read port 1 addresses the zero register
  logic             w_rd2_zero; // read port 2 addresses the zero register

  assign w_stored = r_mem[waddr];

  // Byte-lane merge: enabled lanes take wdata, the others keep the stored bytes.
  always_comb begin
    w_merged = w_stored;
    for (int k = 0; k < NB; k++) begin
      if (wbe[k]) begin
        w_merged[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

  assign w_wr_zero  = (ZERO_REG != 0) && (waddr == AW'(0));
  assign w_wr_en    = we && !w_wr_zero;
  assign w_rd1_zero = (ZERO_REG != 0) && (raddr1 == AW'(0));
  assign w_rd2_zero = (ZERO_REG != 0) && (raddr2 == AW'(0));

  // Forwarding is only meaningful when the write will really land. A reset on
  // the same edge discards the write, so the stored value is shown instead.
  assign w_fwd1 = (BYPASS != 0) && we && !reset && (raddr1 == waddr);
  assign w_fwd2 = (BYPASS != 0) && we && !reset && (raddr2 == waddr);

  // Storage update on the falling edge: reset clears everything, else commit the write.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= w_merged;
    end
  end

  // Read port 1: zero register wins, then the forwarded write, then storage.
  always_comb begin
    rdata1 = r_mem[raddr1];
    if (w_rd1_zero) begin
      rdata1 = '0;
    end else if (w_fwd1) begin
      rdata1 = w_merged;
    end
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    rdata2 = r_mem[raddr2];
    if (w_rd2_zero) begin
      rdata2 = '0;
    end else if (w_fwd2) begin
      rdata2 = w_merged;
    end
  end

endmodule

// File: tb/tb_reg_file_ne.sv
// tb_reg_file_ne: directed bench for reg_file_ne.
// Two instances share all inputs: dut_a uses the defaults (zero register and
// forwarding on), and dut_b has both features off. A reference model of the
// register contents is updated on each falling edge. A compare process checks
// all four read outputs against it at every rising edge, which falls mid-cycle
// between state updates. Directed steps add literal expectations.
module tb_reg_file_ne;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NB = 4;

  logic          clk;
  logic          reset;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [NB-1:0] wbe;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [W-1:0]  a_rd1, a_rd2, b_rd1, b_rd2;

  int checks = 0;
  int errors = 0;

  // Clock/reset block: state changes on falling edges (5, 15, ...), outputs are sampled on rising edges.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  reg_file_ne #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr1(raddr1), .rdata1(a_rd1), .raddr2(raddr2), .rdata2(a_rd2)
  );

  reg_file_ne #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr1(raddr1), .rdata1(b_rd1), .raddr2(raddr2), .rdata2(b_rd2)
  );

  // Reference model: one array per configuration.
  logic [W-1:0] mem_a [D];
  logic [W-1:0] mem_b [D];
  bit           model_ok = 1'b0;

  function automatic logic [W-1:0] byte_mask(input logic [NB-1:0] be);
    logic [W-1:0] m = '0;
    for (int k = 0; k < NB; k++) if (be[k]) m = m | (32'hFF << (8 * k));
    return m;
  endfunction

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                         input logic [W-1:0] new_v,
                                         input logic [NB-1:0] be);
    logic [W-1:0] m = byte_mask(be);
    return (old_v & ~m) | (new_v & m);
  endfunction

  function automatic logic [W-1:0] exp_a(input logic [AW-1:0] addr);
    if (addr == 0) return '0;
    if (we && !reset && addr == waddr) return merge(mem_a[addr], wdata, wbe);
    return mem_a[addr];
  endfunction

  function automatic logic [W-1:0] exp_b(input logic [AW-1:0] addr);
    return mem_b[addr];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        mem_a[i] = '0;
        mem_b[i] = '0;
      end
      model_ok = 1'b1;
    end else if (we) begin
      if (waddr != 0) mem_a[waddr] = merge(mem_a[waddr], wdata, wbe);
      mem_b[waddr] = merge(mem_b[waddr], wdata, wbe);
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every rising edge once the model is defined.
  always @(posedge clk) begin
    if (model_ok) begin
      check("cmp_a_rd1", a_rd1, exp_a(raddr1));
      check("cmp_a_rd2", a_rd2, exp_a(raddr2));
      check("cmp_b_rd1", b_rd1, exp_b(raddr1));
      check("cmp_b_rd2", b_rd2, exp_b(raddr2));
    end
  end

  // Driver tasks: inputs change 1 time unit after a falling edge. Reads are sampled 1 unit after the rising edge.
  task automatic commit();
    @(negedge clk);
    #1;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic w, input logic [AW-1:0] a,
                           input logic [W-1:0] d, input logic [NB-1:0] be);
    we = w; waddr = a; wdata = d; wbe = be;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1;
    set_write(1'b0, '0, '0, '0);
    raddr1 = '0;
    raddr2 = '0;

    // Reset then readback of every address on both ports, both configurations.
    commit();
    reset = 1'b0;
    for (int a = 0; a < D; a++) begin
      raddr1 = AW'(a);
      raddr2 = AW'(D - 1 - a);
      sample();
      check("rst_a_rd1", a_rd1, 32'h0);
      check("rst_a_rd2", a_rd2, 32'h0);
      check("rst_b_rd1", b_rd1, 32'h0);
      commit();
    end

    // Full write to reg5, neighbours stay untouched.
    set_write(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    commit();
    set_write(1'b0, '0, '0, '0);
    raddr1 = 5'd5;
    raddr2 = 5'd4;
    sample();
    check("full_rd5", a_rd1, 32'hDEADBEEF);
    check("full_rd4", a_rd2, 32'h0);
    check("full_b_rd5", b_rd1, 32'hDEADBEEF);
    raddr2 = 5'd6;
    #1;
    check("full_rd6", a_rd2, 32'h0);
    commit();

    // Partial write, lanes 0 and 2 only.
    set_write(1'b1, 5'd5, 32'h11223344, 4'b0101);
    commit();
    set_write(1'b0, '0, '0, '0);
    sample();
    check("part_a_rd5", a_rd1, 32'hDE22BE44);
    check("part_b_rd5", b_rd1, 32'hDE22BE44);
    commit();

    // Zero register: a write to address 0 is discarded only when ZERO_REG=1.
    raddr1 = 5'd0;
    set_write(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
    sample();
    check("zero_pre_a", a_rd1, 32'h0);
    check("zero_pre_b", b_rd1, 32'h0);
    commit();
    set_write(1'b0, '0, '0, '0);
    sample();
    check("zero_post_a", a_rd1, 32'h0);
    check("zero_post_b", b_rd1, 32'hFFFFFFFF);
    commit();

    // Forwarding vs. no forwarding.
    raddr1 = 5'd7;
    raddr2 = 5'd7;
    set_write(1'b1, 5'd7, 32'hA5A5A5A5, 4'hF);
    sample();
    check("byp_pre_a1", a_rd1, 32'hA5A5A5A5);
    check("byp_pre_a2", a_rd2, 32'hA5A5A5A5);
    check("byp_pre_b1", b_rd1, 32'h0);
    check("byp_pre_b2", b_rd2, 32'h0);
    commit();
    set_write(1'b0, '0, '0, '0);
    sample();
    check("byp_post_a1", a_rd1, 32'hA5A5A5A5);
    check("byp_post_b2", b_rd2, 32'hA5A5A5A5);
    commit();

    // wbe all zero changes nothing. A one-lane write forwards the merged value.
    raddr1 = 5'd5;
    set_write(1'b1, 5'd5, 32'h99999999, 4'h0);
    commit();
    set_write(1'b1, 5'd5, 32'h77000000, 4'b1000);
    sample();
    check("nobe_rd5", b_rd1, 32'hDE22BE44);
    check("lane3_fwd", a_rd1, 32'h7722BE44);
    commit();

    // Reset vs. write on the same edge. Reset has no effect before the edge.
    set_write(1'b1, 5'd3, 32'hCAFEF00D, 4'hF);
    commit();
    reset = 1'b1;
    set_write(1'b1, 5'd3, 32'h12345678, 4'hF);
    raddr1 = 5'd3;
    raddr2 = 5'd5;
    sample();
    check("rstw_pre_a3", a_rd1, 32'hCAFEF00D);
    check("rstw_pre_a5", a_rd2, 32'h7722BE44);
    commit();
    reset = 1'b0;
    set_write(1'b0, '0, '0, '0);
    sample();
    check("rstw_post_a3", a_rd1, 32'h0);
    check("rstw_post_b3", b_rd1, 32'h0);
    check("rstw_post_a5", a_rd2, 32'h0);
    commit();

    // Mixed traffic, checked by the compare process against the model.
    for (int n = 0; n < 60; n++) begin
      reset  = ($urandom_range(0, 19) == 0);
      set_write(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                $urandom, NB'($urandom_range(0, 15)));
      raddr1 = AW'($urandom_range(0, 7));
      raddr2 = (n % 3 == 0) ? waddr : AW'($urandom_range(0, 7));
      commit();
    end
    reset = 1'b0;
    set_write(1'b0, '0, '0, '0);
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_ne.md
REG_FILE_NE -- requirements
Module: reg_file_ne

Interface
Parameters (one per line: name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 32: data width in bits; a multiple of 8, minimum 8.
REQ-002 The block SHALL have parameter DEPTH, default 32: number of registers; a power of two, minimum 2.
REQ-003 The block SHALL have parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-004 The block SHALL have parameter BYPASS, default 1: when 1, a same-address pending write is forwarded to the read ports.
REQ-005 The block SHALL derive AW = log2(DEPTH) and NB = WIDTH/8 internally, not as ports.

Ports (one per line: name, direction, width, meaning):
REQ-006 The block SHALL have port clk, input, 1: single clock, state updates on its falling edge.
REQ-007 The block SHALL have port reset, input, 1: synchronous, active-high; clears all state.
REQ-008 The block SHALL have port we, input, 1: write enable.
REQ-009 The block SHALL have port waddr, input, AW: write address.
REQ-010 The block SHALL have port wdata, input, WIDTH: write data.
REQ-011 The block SHALL have port wbe, input, NB: byte enables; bit k covers wdata[8k+7:8k].
REQ-012 The block SHALL have port raddr1, input, AW: read port 1 address.
REQ-013 The block SHALL have port rdata1, output, WIDTH: read port 1 data.
REQ-014 The block SHALL have port raddr2, input, AW: read port 2 address.
REQ-015 The block SHALL have port rdata2, output, WIDTH: read port 2 data.
REQ-016 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-017 The block SHALL hold DEPTH registers of WIDTH bits, all updated only on the falling edge of clk.
REQ-018 On a falling edge with reset=0 and we=1, register[waddr] byte k SHALL take wdata byte k where wbe[k]=1, and SHALL keep its old value where wbe[k]=0.
REQ-019 With we=0, or with wbe all zero, no register SHALL change.
REQ-020 Only register[waddr] SHALL change on a write; all other registers SHALL hold.
REQ-021 Read ports SHALL be combinational with zero-cycle latency: rdataN = register[raddrN] when no forwarding applies.
REQ-022 Both read ports SHALL be independent; raddr1 == raddr2 SHALL return identical data on both ports.
REQ-023 ZERO_REG=1: writes to address 0 SHALL be discarded, and rdataN SHALL be 0 whenever raddrN=0, including while forwarding.
REQ-024 ZERO_REG=0: register 0 SHALL behave as an ordinary register.
REQ-025 BYPASS=1 with we=1, reset=0, and raddrN==waddr (and not the zero register): rdataN SHALL equal the merged value, i.e. wdata bytes where wbe=1 and stored bytes elsewhere, combinationally before the edge.
REQ-026 BYPASS=0: rdataN SHALL show the stored value until the falling edge, then the new value.
REQ-027 Forwarding SHALL be suppressed while reset=1.

Reset
REQ-028 On a falling edge with reset=1, every register SHALL become 0, regardless of we.
REQ-029 After reset, rdata1 and rdata2 SHALL read 0 for every address.
REQ-030 Reset asserted mid-stream SHALL discard a write presented on the same edge.
REQ-031 Reset SHALL have no asynchronous effect: contents SHALL hold until the next falling edge.

Verification
REQ-032 The bench SHALL cover reset then readback: reset=1 for 1 edge -> rdata1/rdata2 = 0x00000000 for raddr 0..31.
REQ-033 The bench SHALL cover full write with isolation: we=1, waddr=5, wdata=0xDEADBEEF, wbe=0xF, one edge -> raddr1=5 reads 0xDEADBEEF, and raddr2=4 and raddr2=6 read 0.
REQ-034 The bench SHALL cover a partial write: reg5=0xDEADBEEF; we=1, wdata=0x11223344, wbe=0b0101 -> reg5 = 0xDE22BE44.
REQ-035 The bench SHALL cover the zero register (ZERO_REG=1): write 0xFFFFFFFF to address 0 -> rdata1=0 both before and after the edge.
REQ-036 The bench SHALL cover bypass (BYPASS=1): reg7=0; we=1, waddr=7, wdata=0xA5A5A5A5, wbe=0xF, raddr1=raddr2=7 -> both ports read 0xA5A5A5A5 before the edge; with BYPASS=0 they read 0 before the edge and 0xA5A5A5A5 after.
REQ-037 The bench SHALL cover reset versus write: reset=1, we=1, waddr=3, wdata=0x12345678 on the same edge -> reg3=0; reset has no effect until the edge.
